rmii_rx_framer: RTL and testbench

Receive-side RMII front end. It samples the PHY's CRS_DV/RXD pins at 50 MHz and strips the preamble and SFD. Payload dibits (destination MAC through FCS) are forwarded on the same inclk/in/in_done dibit stream that eth_rx consumes. It is the pin-side counterpart of eth_tx's dibit output, and its done/err pulses drive the receive path's reset/commit logic.

---
 rtl/rmii_rx_framer.sv | 168 ++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_framer.sv
// rtl/rmii_rx_framer.sv - RMII receive framer: strips preamble/SFD, forwards payload dibits
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE    = 8,
  parameter int MAX_PREAMBLE    = 32,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(4*MAX_FRAME_BYTES+2);
  localparam int PW = $clog2(MAX_PREAMBLE+1);
  localparam logic [CW-1:0] MAX_DIBITS = CW'(4*MAX_FRAME_BYTES);
  localparam logic [CW-1:0] MIN_DIBITS = CW'(4*MIN_FRAME_BYTES);
  localparam logic [PW-1:0] PRE_MIN    = PW'(MIN_PREAMBLE);
  localparam logic [PW-1:0] PRE_MAX    = PW'(MAX_PREAMBLE);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_pre_cnt, w_pre_cnt;
  logic [CW-1:0] r_dib_cnt, w_dib_cnt;
  logic [1:0]    r_hold, w_hold;
  logic          r_hv, w_hv;
  logic          r_crs_d;
  logic          r_armed;
  logic          r_outclk, w_outclk;
  logic [1:0]    r_out, w_out;
  logic          r_done, w_done;
  logic          r_err, w_err;

  always_comb begin
    w_state   = r_state;
    w_pre_cnt = r_pre_cnt;
    w_dib_cnt = r_dib_cnt;
    w_hold    = r_hold;
    w_hv      = r_hv;
    w_outclk  = 1'b0;
    w_out     = r_out;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // After a reset the carrier may still belong to an abandoned frame; wait for it to drop.
        if (crsdv) begin
          if (!r_armed) begin
            w_state = S_DROP;
          end else if (rxd == 2'b01) begin
            w_state   = S_PREAMBLE;
            w_pre_cnt = PW'(1);
          end else if (rxd == 2'b00) begin
            w_state   = S_PREAMBLE;
            w_pre_cnt = '0;
          end else begin
            w_state = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!crsdv) begin
          w_state = S_IDLE;
        end else begin
          case (rxd)
            2'b01: begin
              if (r_pre_cnt + PW'(1) == PRE_MAX) begin
                w_state = S_DROP;
                w_err   = 1'b1;
              end else begin
                w_pre_cnt = r_pre_cnt + PW'(1);
              end
            end
            2'b11: begin
              if (r_pre_cnt >= PRE_MIN) begin
                w_state   = S_DATA;
                w_hv      = 1'b0;
                w_dib_cnt = '0;
              end else begin
                w_state = S_DROP;
                w_err   = 1'b1;
              end
            end
            2'b00: begin
              if (r_pre_cnt != '0) begin
                w_state = S_DROP;
                w_err   = 1'b1;
              end
            end
            default: begin
              w_state = S_DROP;
              w_err   = 1'b1;
            end
          endcase
        end
      end
      S_DATA: begin
        w_hold = rxd;
        w_hv   = 1'b1;
        // The held dibit is valid if carrier was high when sampled or returns high now (toggle).
        if (r_hv) begin
          if (r_crs_d || crsdv) begin
            if (r_dib_cnt == MAX_DIBITS) begin
              w_state = S_DROP;
              w_err   = 1'b1;
            end else begin
              w_outclk  = 1'b1;
              w_out     = r_hold;
              w_dib_cnt = r_dib_cnt + CW'(1);
            end
          end else begin
            w_state = S_IDLE;
            if (r_dib_cnt[1:0] == 2'b00 && r_dib_cnt >= MIN_DIBITS && r_dib_cnt <= MAX_DIBITS)
              w_done = 1'b1;
            else
              w_err = 1'b1;
          end
        end
      end
      default: begin
        if (!crsdv && !r_crs_d)
          w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pre_cnt <= '0;
      r_dib_cnt <= '0;
      r_hold    <= '0;
      r_hv      <= 1'b0;
      r_crs_d   <= 1'b0;
      r_armed   <= 1'b0;
      r_outclk  <= 1'b0;
      r_out     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pre_cnt <= w_pre_cnt;
      r_dib_cnt <= w_dib_cnt;
      r_hold    <= w_hold;
      r_hv      <= w_hv;
      r_crs_d   <= crsdv;
      if (!crsdv)
        r_armed <= 1'b1;
      r_outclk  <= w_outclk;
      r_out     <= w_out;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign outclk = r_outclk;
  assign out    = r_out;
  assign done   = r_done;
  assign err    = r_err;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_rmii_rx_framer.sv
// tb/tb_rmii_rx_framer.sv - scoreboard testbench for rmii_rx_framer
module tb_rmii_rx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       outclk;
  logic [1:0] out;
  logic       done;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int n_outclk = 0;
  int n_done = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  rmii_rx_framer dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .outclk(outclk), .out(out), .done(done), .err(err), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (outclk) begin
      n_outclk++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_outclk: out=%0d with empty scoreboard at %0t", out, $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL payload_dibit: got %0d expected %0d at %0t", out, e, $time);
        end
      end
    end
    if (done) n_done++;
    if (err) n_err++;
    if (done || err) begin
      checks++;
      if (done && err) begin
        errors++;
        $display("FAIL done_err_overlap: done=%0b err=%0b expected not both", done, err);
      end
    end
  end

  task automatic drive(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int pre_n, input int pay_n, input int n_push, input bit toggle_end);
    logic [1:0] d;
    logic c;
    repeat (pre_n) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < pay_n; i++) begin
      d = 2'($urandom_range(0, 3));
      c = 1'b1;
      if (toggle_end && i >= pay_n - 4) c = ((i - (pay_n - 4)) % 2) == 1;
      if (i < n_push) exp_q.push_back(d);
      drive(c, d);
    end
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
  endtask

  task automatic check_counts(input string name, input int o0, input int d0, input int e0,
                              input int o_exp, input int d_exp, input int e_exp);
    checks += 4;
    if (n_outclk - o0 !== o_exp) begin
      errors++;
      $display("FAIL %s_outclk: got %0d expected %0d", name, n_outclk - o0, o_exp);
    end
    if (n_done - d0 !== d_exp) begin
      errors++;
      $display("FAIL %s_done: got %0d expected %0d", name, n_done - d0, d_exp);
    end
    if (n_err - e0 !== e_exp) begin
      errors++;
      $display("FAIL %s_err: got %0d expected %0d", name, n_err - e0, e_exp);
    end
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d queued dibits expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({outclk, out, done, err, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {outclk, out, done, err, busy});
    end
    rst = 1'b0;
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
  endtask

  task automatic test_nominal();
    int o0 = n_outclk, d0 = n_done, e0 = n_err;
    send_frame(31, 256, 256, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done_timing: done=%0b busy=%0b expected done=1 busy=0", done, busy);
    end
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check_counts("nominal", o0, d0, e0, 256, 1, 0);
  endtask

  task automatic test_toggle_end();
    int o0 = n_outclk, d0 = n_done, e0 = n_err;
    send_frame(31, 256, 256, 1'b1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL toggle_done_timing: done=%0b expected 1", done);
    end
    drive(1'b0, 2'b00);
    check_counts("toggle", o0, d0, e0, 256, 1, 0);
  endtask

  task automatic test_length();
    int o0, d0, e0;
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    send_frame(31, 255, 255, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_err_timing: err=%0b expected 1", err);
    end
    drive(1'b0, 2'b00);
    check_counts("misaligned", o0, d0, e0, 255, 0, 1);
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    send_frame(31, 240, 240, 1'b0);
    drive(1'b0, 2'b00);
    check_counts("runt", o0, d0, e0, 240, 0, 1);
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    send_frame(31, 6090, 6088, 1'b0);
    drive(1'b0, 2'b00);
    check_counts("oversize", o0, d0, e0, 6088, 0, 1);
  endtask

  task automatic test_preamble();
    int o0, d0, e0;
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    send_frame(5, 20, 0, 1'b0);
    drive(1'b0, 2'b00);
    check_counts("short_pre", o0, d0, e0, 0, 0, 1);
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    repeat (31) drive(1'b1, 2'b01);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL long_pre_early: err=%0b expected 0 after 31 dibits", err);
    end
    drive(1'b1, 2'b01);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL long_pre_err: err=%0b busy=%0b expected err=1 busy=1", err, busy);
    end
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    repeat (8) drive(1'b1, 2'b10);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check_counts("long_pre", o0, d0, e0, 0, 0, 1);
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    repeat (16) drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check_counts("bad_pre", o0, d0, e0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_frame();
    int o0 = n_outclk, d0 = n_done, e0 = n_err;
    logic [1:0] d;
    repeat (31) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 256; i++) begin
      d = 2'($urandom_range(0, 3));
      if (i < 99) exp_q.push_back(d);
      rst = (i == 100);
      drive(1'b1, d);
      if (i == 100) begin
        checks++;
        if ({outclk, out, done, err, busy} !== 6'b0) begin
          errors++;
          $display("FAIL midreset_outputs: got %b expected 000000", {outclk, out, done, err, busy});
        end
      end
    end
    rst = 1'b0;
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check_counts("midreset", o0, d0, e0, 99, 0, 0);
    o0 = n_outclk; d0 = n_done; e0 = n_err;
    send_frame(31, 256, 256, 1'b0);
    drive(1'b0, 2'b00);
    check_counts("after_reset", o0, d0, e0, 256, 1, 0);
  endtask

  task automatic test_back_to_back();
    int o0 = n_outclk, d0 = n_done, e0 = n_err;
    send_frame(31, 256, 256, 1'b0);
    send_frame(31, 256, 256, 1'b0);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    check_counts("back_to_back", o0, d0, e0, 512, 2, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_toggle_end();
    test_length();
    test_preamble();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
